diffusion_stage: RTL



---
 rtl/diffusion_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/diffusion_stage.sv
// -----------------------------------------------------------------------------
// diffusion_stage
//
// Registered linear diffusion layer of one Ascon permutation round. It takes
// the 5x64-bit state from the substitution layer and XOR-rotates each word
// with that word's two rotation amounts. The result and a round-tag sideband
// go into a 2-entry elastic buffer. Both sides use valid/ready handshakes.
//
// Ports
//   clock_i   in   1        system clock, rising edge
//   reset_i   in   1        synchronous active-high reset
//   state_i   in   5x64     state from substitution layer, word w = state_i[w]
//   tag_i     in   TAG_W    round index travelling with state_i
//   valid_i   in   1        state_i/tag_i valid
//   ready_o   out  1        stage can accept a state this cycle
//   state_o   out  5x64     diffused state at the buffer head
//   tag_o     out  TAG_W    tag of the buffer head
//   valid_o   out  1        head entry valid
//   ready_i   in   1        downstream accepts the head entry
//
// Optional build macro DIFFUSION_STATS_EN adds:
//   count_o   out  16       saturating count of pops since reset
//   stall_o   out  1        valid_o & ~ready_i
//
// DEPTH is fixed at 2. The 1-bit pointers and the 0..2 occupancy count
// assume that value.
// -----------------------------------------------------------------------------
module diffusion_stage #(
   parameter int TAG_W = 4,
   parameter int DEPTH = 2
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic [4:0][63:0]  state_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic [4:0][63:0]  state_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic              valid_o,
   input  logic              ready_i
`ifdef DIFFUSION_STATS_EN
   ,
   output logic [15:0]       count_o,
   output logic              stall_o
`endif
);

   // Per-word rotation amounts. Element gi belongs to word gi.
   localparam logic [4:0][5:0] ROT_A = {6'd7,  6'd10, 6'd1, 6'd61, 6'd19};
   localparam logic [4:0][5:0] ROT_B = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};

   function automatic logic [63:0] rotr(input logic [63:0] x, input logic [5:0] n);
      return (x >> n) | (x << (7'd64 - {1'b0, n}));
   endfunction

   logic [4:0][63:0]  w_diff;
   logic              w_push;
   logic              w_pop;

   logic [1:0]        r_cnt;
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [4:0][63:0]  r_mem_state [DEPTH];
   logic [TAG_W-1:0]  r_mem_tag   [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_word
         assign w_diff[gi] = state_i[gi]
                           ^ rotr(state_i[gi], ROT_A[gi])
                           ^ rotr(state_i[gi], ROT_B[gi]);
      end
   endgenerate

   // Flow control comes only from the occupancy register. ready_o therefore
   // has no combinational path from ready_i. This keeps ready_o low for a
   // full buffer even in a cycle where a pop is also happening.
   assign ready_o = (r_cnt != 2'd2);
   assign valid_o = (r_cnt != 2'd0);
   assign w_push  = valid_i & ready_o;
   assign w_pop   = valid_o & ready_i;

   assign state_o = r_mem_state[r_rd_ptr];
   assign tag_o   = r_mem_tag[r_rd_ptr];

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_cnt    <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Entry storage has no reset. Occupancy alone decides what is live.
   always_ff @(posedge clock_i) begin
      if (w_push && !reset_i) begin
         r_mem_state[r_wr_ptr] <= w_diff;
         r_mem_tag[r_wr_ptr]   <= tag_i;
      end
   end

`ifdef DIFFUSION_STATS_EN
   logic [15:0] r_count;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_count <= 16'd0;
      end else if (w_pop && (r_count != 16'hFFFF)) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign count_o = r_count;
   assign stall_o = valid_o & ~ready_i;
`endif

endmodule
